// File: rtl/backprop_seq_pkg.sv
// Shared types and constants for the backprop layer sequencer and its skew tracker.
package backprop_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    localparam int unsigned LAYER_W_DEF = 8;
    localparam int unsigned STALL_W     = 32;

endpackage

// File: rtl/valid_skew_tracker.sv
// Shift register of row-accept flags mirroring the column skew of the prep stage:
// an accept in cycle t shows up on lane k in cycle t+1+k.
module valid_skew_tracker #(
    parameter int unsigned size = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            accept,
    output logic [size-1:0] lane_valid
);

    logic [size-1:0] skew_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            skew_q <= '0;
        end else begin
            skew_q <= size'({skew_q, accept});
        end
    end

    assign lane_valid = skew_q;

endmodule

// File: rtl/backprop_layer_sequencer.sv
// Layer-by-layer controller for the z-to-z derivative datapath.
// Optional stall counter output enabled by defining BACKPROP_SEQ_PERF_EN.
module backprop_layer_sequencer
    import backprop_seq_pkg::*;
#(
    parameter int unsigned data_size = 16,
    parameter int unsigned size      = 3,
    parameter int unsigned layer_w   = LAYER_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [layer_w-1:0] layer_count,
    input  logic               act_valid,
    output logic               act_ready,
    input  logic               row_valid,
    output logic               row_ready,
    output logic               set_diff_act,
    output logic               start_new_layer,
    output logic [size-1:0]    lane_valid,
    output logic [layer_w-1:0] layer_idx,
    output logic               busy,
    output logic               done
`ifdef BACKPROP_SEQ_PERF_EN
    ,
    output logic [STALL_W-1:0] stall_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(size + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(size - 1);

    seq_state_t         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [layer_w-1:0] idx_q;
    logic [layer_w-1:0] lc_q;
    logic               act_ready_q;
    logic               row_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               row_accept_c;
    logic               unused_data_size;

    // Element width only matters to the datapath instance beside us.
    assign unused_data_size = ^32'(data_size);

    assign row_accept_c = row_ready_q & row_valid;

    // State plus registered Moore outputs, updated together on each transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            lc_q        <= '0;
            act_ready_q <= 1'b0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lc_q   <= layer_count;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (layer_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_LOAD;
                            act_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (act_valid) begin
                        state_q     <= ST_STREAM;
                        act_ready_q <= 1'b0;
                        row_ready_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (row_accept_c) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q       <= '0;
                            state_q     <= ST_DRAIN;
                            row_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == lc_q - layer_w'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_LOAD;
                            idx_q       <= idx_q + layer_w'(1);
                            act_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    act_ready_q <= 1'b0;
                    row_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign act_ready       = act_ready_q;
    assign row_ready       = row_ready_q;
    assign set_diff_act    = act_ready_q & act_valid;
    assign start_new_layer = act_ready_q & act_valid;
    assign layer_idx       = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;

    valid_skew_tracker #(
        .size(size)
    ) u_skew (
        .clk        (clk),
        .reset      (reset),
        .accept     (row_accept_c),
        .lane_valid (lane_valid)
    );

`ifdef BACKPROP_SEQ_PERF_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating count of cycles spent waiting on an upstream valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            stall_q <= '0;
        end else if (((state_q == ST_LOAD && !act_valid) ||
                      (state_q == ST_STREAM && !row_valid)) && stall_q != '1) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
